// File: rtl/icp_pkg.sv
// Shared definitions for the instruction/data program memory: FSM states,
// word geometry and the address-validity rule used by the memory controller.
package icp_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DUMP  = 2'd3
    } state_e;

    // A byte address is usable only if word aligned and inside the 2**aw word array.
    function automatic logic addr_ok(input logic [31:0] addr, input int aw);
        return (addr[1:0] == 2'b00) && ((addr >> (aw + 2)) == 32'd0);
    endfunction

endpackage

// File: rtl/icp_mem_if.sv
// Processor bus, host load stream and host dump stream of icp_mem bundled together.
// The slave modport is the memory side; the master modport is the processor/host side.
interface icp_mem_if;
    import icp_pkg::*;

    logic              i_read_en;
    logic [31:0]       i_read_addr;
    logic [WORD_W-1:0] o_data_out;
    logic              i_write_en;
    logic [31:0]       i_write_addr;
    logic [WORD_W-1:0] i_data_in;
    logic              o_cpu_rst;
    logic              i_load_valid;
    logic              o_load_ready;
    logic [WORD_W-1:0] i_load_data;
    logic              i_load_last;
    logic              i_dump_req;
    logic              o_dump_valid;
    logic              i_dump_ready;
    logic [WORD_W-1:0] o_dump_data;
    logic              o_dump_last;
    logic              o_fault;

    modport slave (
        input  i_read_en, i_read_addr, i_write_en, i_write_addr, i_data_in,
        input  i_load_valid, i_load_data, i_load_last,
        input  i_dump_req, i_dump_ready,
        output o_data_out, o_cpu_rst, o_load_ready,
        output o_dump_valid, o_dump_data, o_dump_last, o_fault
    );

    modport master (
        output i_read_en, i_read_addr, i_write_en, i_write_addr, i_data_in,
        output i_load_valid, i_load_data, i_load_last,
        output i_dump_req, i_dump_ready,
        input  o_data_out, o_cpu_rst, o_load_ready,
        input  o_dump_valid, o_dump_data, o_dump_last, o_fault
    );

endinterface

// File: rtl/icp_mem_array.sv
// Word storage: one synchronous write port plus two asynchronous read ports,
// one serving the processor and one serving the host dump stream.
module icp_mem_array
    import icp_pkg::*;
#(
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr_a,
    output logic [WORD_W-1:0] o_rdata_a,
    input  logic [AW-1:0]     i_raddr_b,
    output logic [WORD_W-1:0] o_rdata_b
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = mem_q[i_raddr_a];
    assign o_rdata_b = mem_q[i_raddr_b];

endmodule

// File: rtl/icp_mem.sv
// Program memory with a clear/load/run/dump lifecycle: the host streams a program in,
// the processor runs against it, and the host streams the final contents back out.
module icp_mem
    import icp_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic      i_clk,
    input  logic      i_rst,
    icp_mem_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    state_e            state_q;
    logic [AW-1:0]     ptr_q;
    logic              cpu_rst_q;
    logic              fault_q;
    logic              load_ready_q;
    logic              dump_valid_q;
    logic              dump_last_q;

    logic              mem_we_d;
    logic [AW-1:0]     mem_waddr_d;
    logic [WORD_W-1:0] mem_wdata_d;
    logic [WORD_W-1:0] cpu_rdata;
    logic [WORD_W-1:0] dump_rdata;

    logic              rd_ok;
    logic              wr_ok;
    logic              in_run;
    logic              load_fire;
    logic              dump_fire;
    logic              bad_access;
    logic [AW-1:0]     rd_word;
    logic [AW-1:0]     wr_word;

    assign rd_ok      = addr_ok(bus.i_read_addr, AW);
    assign wr_ok      = addr_ok(bus.i_write_addr, AW);
    assign rd_word    = bus.i_read_addr[AW+1:2];
    assign wr_word    = bus.i_write_addr[AW+1:2];
    assign in_run     = (state_q == ST_RUN) && !i_rst;
    assign load_fire  = load_ready_q && bus.i_load_valid;
    assign dump_fire  = dump_valid_q && bus.i_dump_ready;
    assign bad_access = (bus.i_read_en && !rd_ok) || (bus.i_write_en && !wr_ok);

    // The single write port is shared by clearing, loading and processor stores.
    always_comb begin
        mem_we_d    = 1'b0;
        mem_waddr_d = ptr_q;
        mem_wdata_d = '0;
        unique case (state_q)
            ST_CLEAR: mem_we_d = 1'b1;
            ST_LOAD: begin
                mem_we_d    = load_fire;
                mem_wdata_d = bus.i_load_data;
            end
            ST_RUN: begin
                mem_we_d    = bus.i_write_en && wr_ok;
                mem_waddr_d = wr_word;
                mem_wdata_d = bus.i_data_in;
            end
            default: mem_we_d = 1'b0;
        endcase
        if (i_rst) begin
            mem_we_d = 1'b0;
        end
    end

    icp_mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .i_clk     (i_clk),
        .i_we      (mem_we_d),
        .i_waddr   (mem_waddr_d),
        .i_wdata   (mem_wdata_d),
        .i_raddr_a (rd_word),
        .o_rdata_a (cpu_rdata),
        .i_raddr_b (ptr_q),
        .o_rdata_b (dump_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_CLEAR;
            ptr_q        <= '0;
            cpu_rst_q    <= 1'b1;
            fault_q      <= 1'b0;
            load_ready_q <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_CLEAR: begin
                    if (ptr_q == PTR_LAST) begin
                        state_q      <= ST_LOAD;
                        ptr_q        <= '0;
                        load_ready_q <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + AW'(1);
                    end
                end
                ST_LOAD: begin
                    if (load_fire) begin
                        if (bus.i_load_last || ptr_q == PTR_LAST) begin
                            state_q      <= ST_RUN;
                            ptr_q        <= '0;
                            load_ready_q <= 1'b0;
                            cpu_rst_q    <= 1'b0;
                        end else begin
                            ptr_q <= ptr_q + AW'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (bad_access) begin
                        fault_q <= 1'b1;
                    end
                    if (bus.i_dump_req) begin
                        state_q      <= ST_DUMP;
                        ptr_q        <= '0;
                        cpu_rst_q    <= 1'b1;
                        dump_valid_q <= 1'b1;
                        dump_last_q  <= (PTR_LAST == '0);
                    end
                end
                ST_DUMP: begin
                    if (dump_fire) begin
                        if (ptr_q == PTR_LAST) begin
                            state_q      <= ST_CLEAR;
                            ptr_q        <= '0;
                            dump_valid_q <= 1'b0;
                            dump_last_q  <= 1'b0;
                        end else begin
                            ptr_q       <= ptr_q + AW'(1);
                            dump_last_q <= ((ptr_q + AW'(1)) == PTR_LAST);
                        end
                    end
                end
                default: state_q <= ST_CLEAR;
            endcase
        end
    end

    assign bus.o_data_out   = (in_run && bus.i_read_en && rd_ok) ? cpu_rdata : '0;
    assign bus.o_dump_data  = dump_valid_q ? dump_rdata : '0;
    assign bus.o_dump_valid = dump_valid_q;
    assign bus.o_dump_last  = dump_last_q;
    assign bus.o_load_ready = load_ready_q;
    assign bus.o_cpu_rst    = cpu_rst_q;
    assign bus.o_fault      = fault_q;

endmodule

// File: doc/icp_mem.md
ICP_MEM -- requirements
Module: icp_mem

Interface
REQ-001 SHALL have parameter: DEPTH, 256, number of 32-bit words; power of two, at least 4.
REQ-002 SHALL have port: i_clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port: i_rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port: i_read_en  in  1  processor read request.
REQ-005 SHALL have port: i_read_addr  in  32  processor byte read address.
REQ-006 SHALL have port: o_data_out  out  32  read data returned to the processor.
REQ-007 SHALL have port: i_write_en  in  1  processor write strobe.
REQ-008 SHALL have port: i_write_addr  in  32  processor byte write address.
REQ-009 SHALL have port: i_data_in  in  32  processor write data.
REQ-010 SHALL have port: o_cpu_rst  out  1  holds the processor in reset.
REQ-011 SHALL have ports: i_load_valid in 1, o_load_ready out 1, i_load_data in 32, i_load_last in 1; host program-load stream.
REQ-012 SHALL have ports: i_dump_req in 1, o_dump_valid out 1, i_dump_ready in 1, o_dump_data out 32, o_dump_last out 1; host readback stream.
REQ-013 SHALL have port: o_fault  out  1  sticky bad-access flag.

Function
REQ-014 SHALL implement FSM states CLEAR, LOAD, RUN and DUMP.
REQ-015 SHALL, in CLEAR, zero one word per cycle at pointer 0..DEPTH-1, then enter LOAD with pointer 0 (DEPTH cycles total).
REQ-016 SHALL assert o_load_ready only in LOAD; a beat transfers when valid and ready are both high.
REQ-017 SHALL write each load beat to word[pointer] and increment the pointer.
REQ-018 SHALL enter RUN after a beat with i_load_last=1, or after the beat at pointer DEPTH-1 regardless of last.
REQ-019 SHALL drive o_cpu_rst=1 in every state except RUN; o_cpu_rst=0 from the first RUN cycle.
REQ-020 SHALL, in RUN, drive o_data_out combinationally with word[i_read_addr>>2] when i_read_en=1 and the address is valid, else 0 (zero-cycle latency from the registered address).
REQ-021 SHALL, in RUN, write i_data_in to word[i_write_addr>>2] on an edge with i_write_en=1 and a valid address.
REQ-022 SHALL treat an address as valid only if bits[1:0]=0 and it is below DEPTH*4.
REQ-023 SHALL, for a read or write to an invalid address in RUN, return 0, ignore the write and set o_fault, which stays 1 until reset.
REQ-024 SHALL, when a read and a write hit the same word in the same cycle, return the old contents on o_data_out and update the word at the edge.
REQ-025 SHALL ignore i_read_en and i_write_en outside RUN; o_data_out SHALL be 0 there.
REQ-026 SHALL, on i_dump_req=1 in RUN, enter DUMP with pointer 0 on the next edge; i_dump_req SHALL be ignored in other states.
REQ-027 SHALL, in DUMP, hold o_dump_valid=1 with o_dump_data=word[pointer]; o_dump_last=1 at pointer DEPTH-1.
REQ-028 SHALL advance the pointer on each valid and ready beat; after the last beat, enter CLEAR.
REQ-029 SHALL hold o_dump_data stable while o_dump_valid=1 and i_dump_ready=0.
REQ-030 SHALL ignore load beats outside LOAD: nothing written, and o_load_ready stays 0.

Reset
REQ-031 SHALL, on i_rst=1 in any state, abort immediately and set: state=CLEAR, pointer=0, o_cpu_rst=1, o_fault=0, o_load_ready=0, o_dump_valid=0, o_dump_last=0, o_dump_data=0, o_data_out=0.
REQ-032 SHALL NOT require memory contents to be valid after reset until CLEAR completes.

Structure
REQ-033 SHALL take FSM state encodings and the word/byte width constants from shared package icp_pkg.
REQ-034 SHALL place storage in sub-module icp_mem_array, with one synchronous write port, an asynchronous processor read port and an asynchronous dump/read port.

Verification
REQ-035 SHALL verify: reset, then idle -> o_load_ready rises exactly DEPTH cycles after i_rst falls; o_cpu_rst=1 throughout.
REQ-036 SHALL verify: load 1,0,0,0 then 99 with last on the 5th beat -> o_cpu_rst falls the next cycle; read addr 16 returns 99.
REQ-037 SHALL verify: in RUN, write 0x1234 at addr 8 and read addr 8 the same cycle -> old value 0; the next cycle -> 0x1234.
REQ-038 SHALL verify: read addr 6 or addr DEPTH*4 -> o_data_out=0 and o_fault=1 sticky; a write to addr 6 leaves words 1 and 2 unchanged.
REQ-039 SHALL verify: dump with i_dump_ready toggling 1,0,1 -> DEPTH beats in order, data stable while stalled, o_dump_last on word DEPTH-1, then CLEAR.
REQ-040 SHALL verify: i_rst asserted mid-LOAD (3rd beat) -> o_load_ready=0 next cycle; after the re-clear, word 0 reads 0.
